// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period helper
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } uart_rx_state_t;

    // Clocks per bit, truncating integer division.
    function automatic int unsigned uart_period(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input; both flops
// reset to RST_VAL so the output holds the line's idle level out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of an 8N1-style line, valid/ready word output,
// one-cycle frame_err and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned PERIOD  = uart_period(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF    = PERIOD / 2;
    localparam int unsigned BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned CNT_W   = $clog2(PERIOD);
    localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(PERIOD - 1);
    localparam logic [BIT_W-1:0] DATA_LAST    = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST    = BIT_W'(STOP_BITS - 1);

    generate
        if (PERIOD < 4) begin : g_period_check
            $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    logic rx_s;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

    uart_rx_state_t       state_q,      state_d;
    logic [CNT_W-1:0]     clk_cnt_q,    clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [DATA_BITS-1:0] data_q,       data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 overrun_q,    overrun_d;
    logic                 deliver;
    logic                 accept;

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = RX_START;
                end
            end

            // A start bit that is high again at mid-bit is a glitch: drop silently.
            RX_START: begin
                if (clk_cnt_q == CNT_HALF_END) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            RX_DATA: begin
                if (clk_cnt_q == CNT_BIT_END) begin
                    clk_cnt_d = '0;
                    shift_d   = DATA_BITS'({rx_s, shift_q} >> 1);
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            RX_STOP: begin
                if (clk_cnt_q == CNT_BIT_END) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        bit_cnt_d   = '0;
                        state_d     = RX_BREAK;
                    end else if (bit_cnt_q == STOP_LAST) begin
                        deliver   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = RX_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            // Line held low after a bad frame must return high before re-arming.
            RX_BREAK: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign accept = data_valid_q & data_ready;

    // A delivery coinciding with acceptance replaces the word without overrun.
    always_comb begin
        data_d       = data_q;
        data_valid_d = data_valid_q;
        overrun_d    = 1'b0;
        if (deliver) begin
            if (!data_valid_q || accept) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames at the pin and compares delivered
// words, pulse counts and timing against a frame-level reference model.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ  = 1000000;
    localparam int unsigned BAUD_RATE = 100000;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned P         = 10;
    localparam int unsigned H         = 5;
    localparam int unsigned LAT       = 2 + H + (DATA_BITS + STOP_BITS) * P + 1;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       rx         = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation side: everything the consumer would see.
    logic [7:0]  got_q[$];
    int unsigned fe_cnt      = 0;
    int unsigned ov_cnt      = 0;
    int unsigned ov_cyc      = 0;
    int unsigned dv_hi       = 0;
    int unsigned dv_rise_cyc = 0;
    logic        dv_prev     = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && data_ready) got_q.push_back(data);
            if (frame_err) fe_cnt++;
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            if (data_valid) dv_hi++;
            if (data_valid && !dv_prev) dv_rise_cyc = cyc;
        end
        dv_prev = data_valid;
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: words that must have been handed over, in order.
    logic [7:0]  exp_q[$];
    int unsigned rd_idx = 0;

    task automatic check_words(input string tag);
        logic [31:0] obs;
        check_eq({tag, "_count"}, 32'(got_q.size() - rd_idx), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            obs = (rd_idx + i < got_q.size()) ? 32'(got_q[rd_idx + i]) : 32'hFFFF_FFFF;
            check_eq(tag, obs, 32'(exp_q[i]));
        end
        rd_idx = got_q.size();
        exp_q.delete();
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line_bit(input logic v);
        rx = v;
        idle(P);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, output int unsigned sc);
        sc = cyc;
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(stop_v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sc;
        int unsigned sc2;
        int unsigned fe0;
        int unsigned ov0;
        int unsigned dvh0;
        int unsigned n_bad;
        logic [7:0]  b;
        logic        good;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", data, 0);
        check_eq("rst_valid", data_valid, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(5);

        // Single frame: value, latency, one-cycle valid, no flags.
        fe0 = fe_cnt; ov0 = ov_cnt; dvh0 = dv_hi;
        send_frame(8'hA5, 1'b1, sc);
        idle(5);
        exp_q.push_back(8'hA5);
        check_words("a5_word");
        check_eq("a5_latency", dv_rise_cyc - sc, LAT);
        check_eq("a5_valid_cycles", dv_hi - dvh0, 1);
        check_eq("a5_frame_err", fe_cnt - fe0, 0);
        check_eq("a5_overrun", ov_cnt - ov0, 0);

        // Back-to-back frames with no idle gap.
        fe0 = fe_cnt; ov0 = ov_cnt; dvh0 = dv_hi;
        send_frame(8'h00, 1'b1, sc);
        send_frame(8'hFF, 1'b1, sc);
        send_frame(8'h3C, 1'b1, sc);
        idle(5);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
        check_words("b2b_word");
        check_eq("b2b_last_latency", dv_rise_cyc - sc, LAT);
        check_eq("b2b_valid_cycles", dv_hi - dvh0, 3);
        check_eq("b2b_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        // Short low glitch must not start a frame; next frame timed from idle.
        fe0 = fe_cnt; dvh0 = dv_hi;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        check_words("glitch_none");
        check_eq("glitch_valid", dv_hi - dvh0, 0);
        check_eq("glitch_frame_err", fe_cnt - fe0, 0);
        send_frame(8'h5A, 1'b1, sc);
        idle(5);
        exp_q.push_back(8'h5A);
        check_words("glitch_after_word");
        check_eq("glitch_after_latency", dv_rise_cyc - sc, LAT);

        // Bad stop bit followed by a held-low line.
        fe0 = fe_cnt; dvh0 = dv_hi;
        send_frame(8'h55, 1'b0, sc);
        idle(50);
        check_eq("break_frame_err", fe_cnt - fe0, 1);
        check_eq("break_valid", dv_hi - dvh0, 0);
        check_words("break_none");
        rx = 1'b1;
        idle(P);
        send_frame(8'h12, 1'b1, sc);
        idle(5);
        exp_q.push_back(8'h12);
        check_words("break_after_word");
        check_eq("break_after_frame_err", fe_cnt - fe0, 1);

        // Overrun: second word arrives while first is still unaccepted.
        data_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, sc);
        send_frame(8'h22, 1'b1, sc2);
        idle(3);
        check_eq("ovr_data", data, 8'h11);
        check_eq("ovr_valid", data_valid, 1);
        check_eq("ovr_pulses", ov_cnt - ov0, 1);
        check_eq("ovr_time", ov_cyc - sc2, LAT);
        data_ready = 1'b1;
        idle(1);
        check_eq("ovr_valid_drop", data_valid, 0);
        exp_q.push_back(8'h11);
        check_words("ovr_word");

        // Acceptance on the same edge as the next delivery: no overrun, both words.
        ov0 = ov_cnt;
        data_ready = 1'b0;
        send_frame(8'h33, 1'b1, sc);
        fork
            send_frame(8'h44, 1'b1, sc2);
            begin
                idle(LAT - 1);
                data_ready = 1'b1;
            end
        join
        idle(5);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        check_words("same_edge_word");
        check_eq("same_edge_overrun", ov_cnt - ov0, 0);
        check_eq("same_edge_valid_drop", data_valid, 0);

        // Reset during data bit 4 of 0x99.
        b = 8'h99;
        line_bit(1'b0);
        for (int i = 0; i < 4; i++) line_bit(b[i]);
        rx = b[4];
        idle(3);
        rst = 1'b1;
        #1;
        check_eq("midrst_data", data, 0);
        check_eq("midrst_valid", data_valid, 0);
        check_eq("midrst_frame_err", frame_err, 0);
        check_eq("midrst_overrun", overrun, 0);
        rx = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(3);
        fe0 = fe_cnt;
        send_frame(8'h77, 1'b1, sc);
        idle(5);
        exp_q.push_back(8'h77);
        check_words("midrst_after_word");
        check_eq("midrst_after_latency", dv_rise_cyc - sc, LAT);
        check_eq("midrst_after_frame_err", fe_cnt - fe0, 0);

        // Random frames, random gaps, occasional bad stop bit.
        fe0 = fe_cnt; ov0 = ov_cnt; n_bad = 0;
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(7) != 0);
            send_frame(b, good, sc);
            if (good) begin
                exp_q.push_back(b);
                idle($urandom_range(6));
            end else begin
                n_bad++;
                idle($urandom_range(20));
                rx = 1'b1;
                idle(2 + $urandom_range(5));
            end
        end
        idle(5);
        check_words("rand_word");
        check_eq("rand_frame_err", fe_cnt - fe0, n_bad);
        check_eq("rand_overrun", ov_cnt - ov0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: deserializes an asynchronous 8N1-style serial line into parallel words and presents each word on a valid/ready handshake. It sits in the UART peripheral beside the transmitter and shares its parameter set and bit ordering, so a transmitter→receiver loopback reproduces every word. It synchronizes the line, samples each bit at mid-period, and reports framing errors and overruns.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line bit rate in bit/s
- DATA_BITS, 8, data bits per frame
- STOP_BITS, 1, stop bits per frame; every stop bit is checked
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  reset, asynchronous, active-high
- rx  input  1  serial line, asynchronous to clk; idles high
- data  output  DATA_BITS  received word; stable while data_valid=1
- data_valid  output  1  word available; held until accepted
- data_ready  input  1  consumer accepts the word when data_valid and data_ready are both 1
- frame_err  output  1  one-cycle pulse: a stop bit was sampled as 0
- overrun  output  1  one-cycle pulse: a word completed while data_valid was still 1

## Operation
- PERIOD = CLK_FREQ/BAUD_RATE, using integer division. HALF = PERIOD/2. PERIOD must be ≥ 4; a compile-time assertion enforces this.
- rx passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value rx_s.
- State machine states: IDLE, START, DATA, STOP, BREAK. A single cycle counter clk_cnt and a bit counter bit_cnt drive the transitions.
- IDLE: when rx_s=0, go to START with clk_cnt=0.
- START: when clk_cnt=HALF-1, sample rx_s.
  - If 0, go to DATA with clk_cnt=0 and bit_cnt=0.
  - If 1, treat it as a glitch or false start and go back to IDLE with no flag.
- DATA: when clk_cnt=PERIOD-1, sample rx_s into the shift register, LSB first, and increment bit_cnt.
  - After DATA_BITS samples, go to STOP.
- STOP: sample at PERIOD-1 for each of STOP_BITS.
  - Any 0 sample: pulse frame_err, discard the word, go to BREAK.
  - All 1: deliver the word and go to IDLE.
- BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from re-triggering START.
- Delivery when data_valid=0: load data, set data_valid=1.
- Delivery when data_valid=1 and the word is not accepted in that same cycle: pulse overrun, drop the new word, keep the old data.
- Delivery in the same cycle as an acceptance: the new word loads and data_valid stays 1, with no overrun.
- Counters are sized with $clog2 and wrap only through the explicit resets above. There is no free-running wrap.

## Timing
- Reset values: data=0, data_valid=0, frame_err=0, overrun=0, state=IDLE, counters=0.
- rst asserted mid-frame aborts immediately. After release the FSM is in IDLE and needs a fresh falling edge.
- Synchronizer latency is 2 cycles.
- data_valid rises 2 + HALF + (DATA_BITS+STOP_BITS)·PERIOD + 1 cycles after the rx falling edge at the pin, give or take 1 cycle of synchronizer uncertainty.
- A handshake at edge N clears data_valid at N+1 unless a new word is delivered at N.
- frame_err and overrun are registered, high for exactly one cycle.
- The next frame's start bit is accepted in the cycle after the final stop-bit sample. No extra idle time is required between frames.

## Structure
- uart_pkg holds:
  - the state enum uart_rx_state_t
  - a function computing PERIOD from CLK_FREQ and BAUD_RATE, shared with the transmitter
- Sub-module sync_2ff: a generic 2-flop synchronizer with a reset-value parameter, reusable for other asynchronous inputs.

## Test plan
All scenarios use CLK_FREQ=1000000, BAUD_RATE=100000, so PERIOD=10 and HALF=5.
- Frame 0xA5 with data_ready=1 → data=0xA5, data_valid high 1 cycle, no flags. Assert the rise time against the latency formula.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap and data_ready=1 → three words in order, no flags.
- rx low for 3 cycles, then high → no START accepted, no output, FSM back in IDLE.
- Frame 0x55 with the stop bit forced 0, then rx held low for 50 cycles → frame_err pulses once, data_valid stays 0, no re-trigger until rx returns high. A following 0x12 frame is received correctly.
- data_ready=0; send 0x11 then 0x22 → data=0x11, overrun pulses at 0x22's stop sample. After acceptance, data_valid drops.
- Reset asserted at data bit 4 of frame 0x99 → all outputs reset immediately. A subsequent 0x77 frame is received correctly.
